// File: rtl/ghash_sequencer_if.sv
// rtl/ghash_sequencer_if.sv - block stream, ghash core and result signals of the ghash sequencer
interface ghash_sequencer_if;
  logic         start;
  logic [127:0] h_key;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         in_type;
  logic [4:0]   in_bytes;
  logic         in_last;
  logic [127:0] gh_data;
  logic [127:0] gh_hkey;
  logic [127:0] gh_yprev;
  logic [127:0] gh_yout;
  logic         s_valid;
  logic [127:0] s_data;
  logic         busy;
  logic         err;

  modport slave (
    input  start, h_key, in_valid, in_data, in_type, in_bytes, in_last, gh_yout,
    output in_ready, gh_data, gh_hkey, gh_yprev, s_valid, s_data, busy, err
  );

  modport master (
    output start, h_key, in_valid, in_data, in_type, in_bytes, in_last, gh_yout,
    input  in_ready, gh_data, gh_hkey, gh_yprev, s_valid, s_data, busy, err
  );
endinterface

// File: rtl/ghash_sequencer.sv
// rtl/ghash_sequencer.sv - feeds AAD/ciphertext blocks and the length block through an external ghash core
module ghash_sequencer #(
  parameter int LEN_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  ghash_sequencer_if.slave  bus
);

  localparam int SW = LEN_W + 1;

  typedef enum logic [1:0] {IDLE, ABSORB, LEN, DONE} state_t;

  state_t             state_q, state_d;
  logic [127:0]       y_q, y_d;
  logic [127:0]       h_q, h_d;
  logic [127:0]       s_data_q, s_data_d;
  logic [LEN_W-1:0]   len_a_q, len_a_d;
  logic [LEN_W-1:0]   len_c_q, len_c_d;
  logic               seen_c_q, seen_c_d;
  logic               err_q, err_d;
  logic               s_valid_q, s_valid_d;

  logic [4:0]         bytes_eff;
  logic [127:0]       data_masked;
  logic [SW-1:0]      len_sum;

  assign bytes_eff = (bus.in_bytes > 5'd16) ? 5'd16 : bus.in_bytes;

  always_comb begin
    data_masked = '0;
    for (int i = 0; i < 16; i++) begin
      if (5'(i) < bytes_eff) data_masked[127-8*i -: 8] = bus.in_data[127-8*i -: 8];
    end
  end

  // One adder serves both counters; the carry out is the wrap indication.
  assign len_sum = {1'b0, (bus.in_type ? len_c_q : len_a_q)} + SW'({bytes_eff, 3'b000});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      y_q       <= '0;
      h_q       <= '0;
      s_data_q  <= '0;
      len_a_q   <= '0;
      len_c_q   <= '0;
      seen_c_q  <= 1'b0;
      err_q     <= 1'b0;
      s_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      y_q       <= y_d;
      h_q       <= h_d;
      s_data_q  <= s_data_d;
      len_a_q   <= len_a_d;
      len_c_q   <= len_c_d;
      seen_c_q  <= seen_c_d;
      err_q     <= err_d;
      s_valid_q <= s_valid_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    y_d       = y_q;
    h_d       = h_q;
    s_data_d  = s_data_q;
    len_a_d   = len_a_q;
    len_c_d   = len_c_q;
    seen_c_d  = seen_c_q;
    err_d     = err_q;
    s_valid_d = 1'b0;
    if (bus.start) begin
      state_d  = ABSORB;
      h_d      = bus.h_key;
      y_d      = '0;
      s_data_d = '0;
      len_a_d  = '0;
      len_c_d  = '0;
      seen_c_d = 1'b0;
      err_d    = 1'b0;
    end else begin
      case (state_q)
        ABSORB: begin
          if (bus.in_valid) begin
            if (bytes_eff != 5'd0) begin
              y_d = bus.gh_yout;
              if (bus.in_type) len_c_d = len_sum[LEN_W-1:0];
              else             len_a_d = len_sum[LEN_W-1:0];
              if (len_sum[LEN_W]) err_d = 1'b1;
            end
            // Ordering faults are flagged but the block is still absorbed.
            if (!bus.in_type && seen_c_q) err_d = 1'b1;
            if (!bus.in_last && bytes_eff != 5'd0 && bytes_eff != 5'd16) err_d = 1'b1;
            if (bus.in_bytes > 5'd16) err_d = 1'b1;
            if (bus.in_type) seen_c_d = 1'b1;
            if (bus.in_last) state_d = LEN;
          end
        end
        LEN: begin
          y_d       = bus.gh_yout;
          s_data_d  = bus.gh_yout;
          s_valid_d = 1'b1;
          state_d   = DONE;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus.in_ready = (state_q == ABSORB);
    bus.busy     = (state_q == ABSORB) || (state_q == LEN);
    bus.gh_hkey  = h_q;
    bus.gh_yprev = y_q;
    bus.s_valid  = s_valid_q;
    bus.s_data   = s_data_q;
    bus.err      = err_q;
    case (state_q)
      ABSORB:  bus.gh_data = data_masked;
      LEN:     bus.gh_data = {64'(len_a_q), 64'(len_c_q)};
      default: bus.gh_data = '0;
    endcase
  end

endmodule

// File: tb/tb_ghash_sequencer.sv
// tb/tb_ghash_sequencer.sv - randomized bench for ghash_sequencer with a GF(2^128) core model
module tb_ghash_sequencer;

  localparam int TB_LEN_W = 10;
  localparam logic [127:0] H_VEC = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;

  ghash_sequencer_if bus();

  ghash_sequencer #(.LEN_W(TB_LEN_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [127:0] gf_mul(input logic [127:0] x, input logic [127:0] y);
    logic [127:0] z;
    logic [127:0] v;
    z = '0;
    v = y;
    for (int i = 0; i < 128; i++) begin
      if (x[127-i]) z = z ^ v;
      v = v[0] ? ((v >> 1) ^ {8'he1, 120'h0}) : (v >> 1);
    end
    return z;
  endfunction

  assign bus.gh_yout = gf_mul(bus.gh_yprev ^ bus.gh_data, bus.gh_hkey);

  logic [127:0] m_data [16];
  int           m_bytes [16];
  bit           m_type [16];
  int           m_n;
  logic [127:0] m_h;

  logic [127:0] obs_last_gh;
  logic [127:0] obs_len_gh;
  int           obs_sv_cyc;

  function automatic void model(output logic [127:0] s, output bit e);
    logic [127:0] y;
    longint la, lc, lim;
    int b;
    bit seen_c;
    y = '0; la = 0; lc = 0; e = 0; seen_c = 0;
    lim = longint'(1) << TB_LEN_W;
    for (int i = 0; i < m_n; i++) begin
      b = (m_bytes[i] > 16) ? 16 : m_bytes[i];
      if (m_bytes[i] > 16) e = 1;
      if (i != m_n - 1 && b > 0 && b < 16) e = 1;
      if (!m_type[i] && seen_c) e = 1;
      if (m_type[i]) seen_c = 1;
      if (b > 0) begin
        y = gf_mul(y ^ ((b == 16) ? m_data[i] : (m_data[i] & ({128{1'b1}} << (128 - 8 * b)))), m_h);
        if (m_type[i]) begin
          lc = lc + 8 * b;
          if (lc >= lim) begin e = 1; lc = lc - lim; end
        end else begin
          la = la + 8 * b;
          if (la >= lim) begin e = 1; la = la - lim; end
        end
      end
    end
    s = gf_mul(y ^ {64'(la), 64'(lc)}, m_h);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start = 0; bus.h_key = '0; bus.in_valid = 0; bus.in_data = '0;
    bus.in_type = 0; bus.in_bytes = '0; bus.in_last = 0;
  endtask

  // Plays the message in m_* with in_valid held, then checks timing, S and err against the model.
  task automatic run_msg(input string name, input bit do_start);
    logic [127:0] exp_s;
    bit exp_e;
    int cyc;
    model(exp_s, exp_e);
    cyc = 0;
    if (do_start) begin
      bus.start = 1; bus.h_key = m_h;
      tick();
      bus.start = 0;
    end
    for (int i = 0; i < m_n; i++) begin
      bus.in_valid = 1; bus.in_data = m_data[i]; bus.in_type = m_type[i];
      bus.in_bytes = 5'(m_bytes[i]); bus.in_last = (i == m_n - 1);
      #1;
      n_tests++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL %s in_ready blk%0d: got %b want 1", name, i, bus.in_ready);
      end
      obs_last_gh = bus.gh_data;
      tick(); cyc++;
    end
    idle_inputs();
    obs_len_gh = bus.gh_data;
    n_tests++;
    if (bus.s_valid !== 1'b0 || bus.busy !== 1'b1) begin
      n_fail++; $display("FAIL %s LEN state: s_valid=%b busy=%b want 0/1", name, bus.s_valid, bus.busy);
    end
    tick(); cyc++;
    obs_sv_cyc = bus.s_valid ? cyc : -1;
    n_tests++;
    if (bus.s_valid !== 1'b1) begin
      n_fail++; $display("FAIL %s s_valid latency: got %b want 1", name, bus.s_valid);
    end
    n_tests++;
    if (bus.s_data !== exp_s) begin
      n_fail++; $display("FAIL %s s_data: got %h want %h", name, bus.s_data, exp_s);
    end
    n_tests++;
    if (bus.err !== exp_e) begin
      n_fail++; $display("FAIL %s err: got %b want %b", name, bus.err, exp_e);
    end
    tick();
    n_tests++;
    if (bus.s_valid !== 1'b0 || bus.busy !== 1'b0 || bus.s_data !== exp_s) begin
      n_fail++; $display("FAIL %s after pulse: s_valid=%b busy=%b s_data=%h want 0/0/%h",
                         name, bus.s_valid, bus.busy, bus.s_data, exp_s);
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 0;
    tick(); tick();
    n_tests++;
    if (bus.in_ready !== 0 || bus.s_valid !== 0 || bus.busy !== 0 || bus.err !== 0 ||
        bus.s_data !== '0 || bus.gh_yprev !== '0 || bus.gh_hkey !== '0) begin
      n_fail++; $display("FAIL reset: rdy=%b sv=%b busy=%b err=%b s=%h y=%h h=%h want all 0",
                         bus.in_ready, bus.s_valid, bus.busy, bus.err, bus.s_data, bus.gh_yprev, bus.gh_hkey);
    end
    rst_n = 1;
    tick();
  endtask

  task automatic test_empty();
    m_h = H_VEC; m_n = 1;
    m_data[0] = {$urandom, $urandom, $urandom, $urandom}; m_bytes[0] = 0; m_type[0] = 1;
    run_msg("empty", 1);
    n_tests++;
    if (bus.s_data !== '0) begin
      n_fail++; $display("FAIL empty const: got %h want 0", bus.s_data);
    end
  endtask

  task automatic test_vector();
    m_h = H_VEC; m_n = 1;
    m_data[0] = 128'h0388dace60b6a392f328c2b971b2fe78; m_bytes[0] = 16; m_type[0] = 1;
    run_msg("vector", 1);
    n_tests++;
    if (bus.s_data !== 128'hf38cbb1ad69223dcc3457ae5b6b0f885) begin
      n_fail++; $display("FAIL vector const: got %h want f38cbb1ad69223dcc3457ae5b6b0f885", bus.s_data);
    end
  endtask

  task automatic test_partial();
    m_h = {$urandom, $urandom, $urandom, $urandom}; m_n = 1;
    m_data[0] = {128{1'b1}}; m_bytes[0] = 3; m_type[0] = 1;
    run_msg("partial", 1);
    n_tests++;
    if (obs_last_gh !== {24'hffffff, 104'h0}) begin
      n_fail++; $display("FAIL partial gh_data: got %h want ffffff00..00", obs_last_gh);
    end
    n_tests++;
    if (obs_len_gh !== 128'h18) begin
      n_fail++; $display("FAIL partial len block: got %h want 18", obs_len_gh);
    end
  endtask

  task automatic test_order_err();
    m_h = {$urandom, $urandom, $urandom, $urandom}; m_n = 3;
    for (int i = 0; i < 3; i++) m_data[i] = {$urandom, $urandom, $urandom, $urandom};
    m_type[0] = 1; m_bytes[0] = 16;
    m_type[1] = 0; m_bytes[1] = 16;
    m_type[2] = 1; m_bytes[2] = 7;
    run_msg("order_err", 1);
    bus.start = 1; bus.h_key = m_h;
    tick();
    bus.start = 0;
    n_tests++;
    if (bus.err !== 1'b0 || bus.gh_yprev !== '0) begin
      n_fail++; $display("FAIL order_err start clear: err=%b y=%h want 0/0", bus.err, bus.gh_yprev);
    end
  endtask

  task automatic test_abort();
    bit sv_seen;
    m_h = {$urandom, $urandom, $urandom, $urandom}; m_n = 3;
    for (int i = 0; i < 3; i++) begin
      m_data[i] = {$urandom, $urandom, $urandom, $urandom}; m_bytes[i] = 16; m_type[i] = (i == 2);
    end
    bus.start = 1; bus.h_key = m_h;
    tick();
    bus.start = 0;
    for (int i = 0; i < 2; i++) begin
      bus.in_valid = 1; bus.in_data = m_data[i]; bus.in_type = 1; bus.in_bytes = 5'd16; bus.in_last = 0;
      tick();
    end
    // start coincides with a last block, which must be dropped
    bus.start = 1; bus.in_last = 1;
    tick();
    idle_inputs();
    bus.h_key = m_h;
    n_tests++;
    if (bus.gh_yprev !== '0 || bus.busy !== 1'b1 || bus.err !== 1'b0) begin
      n_fail++; $display("FAIL abort restart: y=%h busy=%b err=%b want 0/1/0", bus.gh_yprev, bus.busy, bus.err);
    end
    sv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      if (bus.s_valid) sv_seen = 1;
      tick();
    end
    n_tests++;
    if (sv_seen !== 1'b0) begin
      n_fail++; $display("FAIL abort s_valid: got pulse want none");
    end
    run_msg("abort_rerun", 0);
  endtask

  task automatic test_reset_in_len();
    bit sv_seen;
    m_h = {$urandom, $urandom, $urandom, $urandom};
    bus.start = 1; bus.h_key = m_h;
    tick();
    bus.start = 0;
    bus.in_valid = 1; bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    bus.in_type = 1; bus.in_bytes = 5'd16; bus.in_last = 1;
    tick();
    idle_inputs();
    rst_n = 0;
    #1;
    n_tests++;
    if (bus.busy !== 0 || bus.in_ready !== 0 || bus.s_valid !== 0 || bus.err !== 0 ||
        bus.s_data !== '0 || bus.gh_yprev !== '0 || bus.gh_hkey !== '0 || bus.gh_data !== '0) begin
      n_fail++; $display("FAIL reset_in_len: busy=%b rdy=%b sv=%b err=%b s=%h y=%h h=%h want all 0",
                         bus.busy, bus.in_ready, bus.s_valid, bus.err, bus.s_data, bus.gh_yprev, bus.gh_hkey);
    end
    sv_seen = 0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.s_valid) sv_seen = 1;
    end
    rst_n = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus.s_valid) sv_seen = 1;
    end
    n_tests++;
    if (sv_seen !== 1'b0 || bus.busy !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_len after: s_valid_seen=%b busy=%b want 0/0", sv_seen, bus.busy);
    end
  endtask

  task automatic test_back_to_back();
    m_h = {$urandom, $urandom, $urandom, $urandom}; m_n = 4;
    for (int i = 0; i < 4; i++) begin
      m_data[i] = {$urandom, $urandom, $urandom, $urandom}; m_bytes[i] = 16; m_type[i] = (i >= 2);
    end
    run_msg("back_to_back", 1);
    n_tests++;
    if (obs_sv_cyc !== 5) begin
      n_fail++; $display("FAIL back_to_back s_valid cycle: got %0d want 5", obs_sv_cyc);
    end
  endtask

  task automatic test_ignore();
    logic [127:0] held;
    held = bus.s_data;
    bus.in_valid = 1; bus.in_bytes = 5'd20; bus.in_type = 0; bus.in_last = 1;
    bus.in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 3; i++) tick();
    n_tests++;
    if (bus.in_ready !== 0 || bus.err !== 0 || bus.busy !== 0 || bus.s_data !== held || bus.s_valid !== 0) begin
      n_fail++; $display("FAIL ignore: rdy=%b err=%b busy=%b sv=%b s=%h want 0/0/0/0/%h",
                         bus.in_ready, bus.err, bus.busy, bus.s_valid, bus.s_data, held);
    end
    idle_inputs();
  endtask

  task automatic test_overflow();
    m_h = {$urandom, $urandom, $urandom, $urandom}; m_n = 8;
    for (int i = 0; i < 8; i++) begin
      m_data[i] = {$urandom, $urandom, $urandom, $urandom}; m_bytes[i] = 16; m_type[i] = 1;
    end
    run_msg("overflow", 1);
  endtask

  task automatic test_random();
    int na, nc;
    for (int k = 0; k < 8; k++) begin
      m_h = {$urandom, $urandom, $urandom, $urandom};
      na = $urandom_range(0, 3);
      nc = $urandom_range(0, 3);
      m_n = (na + nc == 0) ? 1 : na + nc;
      for (int i = 0; i < m_n; i++) begin
        m_data[i] = {$urandom, $urandom, $urandom, $urandom};
        m_type[i] = (i >= na);
        m_bytes[i] = 16;
      end
      m_bytes[m_n-1] = (k == 7) ? $urandom_range(17, 31) : $urandom_range(0, 16);
      run_msg($sformatf("random%0d", k), 1);
    end
  endtask

  initial begin
    test_reset();
    test_ignore();
    test_empty();
    test_vector();
    test_partial();
    test_ignore();
    test_order_err();
    test_abort();
    test_reset_in_len();
    test_back_to_back();
    test_overflow();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
